// File: rtl/free_list_ckpt_ctrl_pkg.sv
// Shared types and constants for the free-list checkpoint controller.
// Holds the checkpoint tag/entry types, the FSM encoding and a counter helper.
package free_list_ckpt_ctrl_pkg;

    localparam int PHYS_REG_SZ_R10K = 64;
    localparam int NUM_CKPT         = 4;
    localparam int CKPT_ID_BITS     = $clog2(NUM_CKPT);

    typedef logic [CKPT_ID_BITS-1:0] CKPT_TAG;

    typedef struct packed {
        logic                        valid;
        logic [PHYS_REG_SZ_R10K-1:0] snapshot;
        logic [NUM_CKPT-1:0]         older_mask;
    } CKPT_ENTRY;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_RESTORE = 1'b1
    } ckpt_state_e;

    // Saturating increment for the statistics counters.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/free_list_ckpt_ctrl_alloc_picker.sv
// Priority encoder returning the lowest-index set bit of free_vec.
// Ports: free_vec (in), idx (out, lowest free index), found (out, any free).
module ckpt_alloc_picker #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   free_vec,
    output logic [IDW-1:0] idx,
    output logic           found
);
    import free_list_ckpt_ctrl_pkg::*;

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (free_vec[i]) begin
                idx   = IDW'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/free_list_ckpt_ctrl.sv
// Branch-checkpoint controller: allocates tags, stores free-list snapshots,
// tracks entry age and drives restore_flag/free_list_restore on mispredict.
// Ports: clock, reset (sync, active-high); dispatch ckpt_req/ckpt_free_list ->
// ckpt_grant/ckpt_tag/ckpt_full; branch unit resolve_valid/resolve_tag/
// resolve_mispredict; free list restore_flag/free_list_restore; live_mask.
// Optional macro CKPT_STATS_EN adds stat_mispredicts, stat_correct and
// stat_full_stall_cycles saturating counters.
module free_list_ckpt_ctrl #(
    parameter int NUM_CKPT     = 4,
    parameter int PHYS_REG_SZ  = 64,
    parameter int CKPT_ID_BITS = $clog2(NUM_CKPT)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    ckpt_req,
    input  logic [PHYS_REG_SZ-1:0]  ckpt_free_list,
    output logic                    ckpt_grant,
    output logic [CKPT_ID_BITS-1:0] ckpt_tag,
    output logic                    ckpt_full,
    input  logic                    resolve_valid,
    input  logic [CKPT_ID_BITS-1:0] resolve_tag,
    input  logic                    resolve_mispredict,
    output logic                    restore_flag,
    output logic [PHYS_REG_SZ-1:0]  free_list_restore,
    output logic [NUM_CKPT-1:0]     live_mask
`ifdef CKPT_STATS_EN
    ,
    output logic [31:0]             stat_mispredicts,
    output logic [31:0]             stat_correct,
    output logic [31:0]             stat_full_stall_cycles
`endif
);
    import free_list_ckpt_ctrl_pkg::*;

    logic [NUM_CKPT-1:0]    valid_q;
    logic [NUM_CKPT-1:0]    valid_d;
    logic [PHYS_REG_SZ-1:0] snap_q  [NUM_CKPT];
    logic [NUM_CKPT-1:0]    older_q [NUM_CKPT];

    ckpt_state_e state_q;
    ckpt_state_e state_d;
    logic        in_run;

    logic                   restore_q;
    logic [PHYS_REG_SZ-1:0] restore_data_q;

    logic                    squash_now;
    logic                    tag_live;
    logic                    mis;
    logic                    cor;
    logic [CKPT_ID_BITS-1:0] pick_idx;
    logic                    pick_found;
    logic                    grant;

    logic [NUM_CKPT-1:0] tag_oh;
    logic [NUM_CKPT-1:0] younger;
    logic [NUM_CKPT-1:0] free_mask;
    logic [NUM_CKPT-1:0] kill_mask;
    logic [NUM_CKPT-1:0] set_mask;

    ckpt_alloc_picker #(
        .N   (NUM_CKPT),
        .IDW (CKPT_ID_BITS)
    ) u_picker (
        .free_vec (~valid_q),
        .idx      (pick_idx),
        .found    (pick_found)
    );

    // FSM: RESTORE is a single cycle that blocks grants and resolves.
    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_RUN;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        in_run  = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                in_run = 1'b1;
                if (mis) state_d = ST_RESTORE;
            end
            ST_RESTORE: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Resolve qualification: only live tags in RUN have any effect.
    assign squash_now = resolve_valid & resolve_mispredict;
    assign tag_live   = valid_q[resolve_tag];
    assign mis        = resolve_valid & in_run & tag_live & resolve_mispredict;
    assign cor        = resolve_valid & in_run & tag_live & ~resolve_mispredict;

    assign ckpt_full  = &valid_q;
    assign grant      = ckpt_req & ~ckpt_full & ~squash_now
                        & in_run & pick_found;
    assign ckpt_grant = grant;
    assign ckpt_tag   = pick_idx;

    always_comb begin
        tag_oh              = '0;
        tag_oh[resolve_tag] = 1'b1;
        set_mask            = '0;
        if (grant) set_mask[pick_idx] = 1'b1;
        // Entries allocated after tag t carry bit t in their older_mask.
        for (int j = 0; j < NUM_CKPT; j++) begin
            younger[j] = older_q[j][resolve_tag];
        end
        free_mask = cor ? tag_oh : '0;
        kill_mask = mis ? (tag_oh | younger) : '0;
        valid_d   = (valid_q & ~free_mask & ~kill_mask) | set_mask;
    end

    always_ff @(posedge clock) begin
        if (reset) valid_q <= '0;
        else       valid_q <= valid_d;
    end

    // Snapshot/age storage needs no reset; valid_q gates every use.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_CKPT; i++) begin
            if (set_mask[i]) begin
                snap_q[i]  <= ckpt_free_list;
                older_q[i] <= valid_q & ~free_mask;
            end else begin
                older_q[i] <= older_q[i] & ~(free_mask | kill_mask);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            restore_q      <= 1'b0;
            restore_data_q <= '0;
        end else begin
            restore_q <= mis;
            if (mis) restore_data_q <= snap_q[resolve_tag];
        end
    end

    assign restore_flag      = restore_q;
    assign free_list_restore = restore_data_q;
    assign live_mask         = valid_q;

`ifdef CKPT_STATS_EN
    logic [31:0] mis_cnt_q;
    logic [31:0] cor_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            mis_cnt_q   <= '0;
            cor_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (mis) mis_cnt_q <= sat_inc(mis_cnt_q);
            if (cor) cor_cnt_q <= sat_inc(cor_cnt_q);
            if (ckpt_req & ckpt_full) stall_cnt_q <= sat_inc(stall_cnt_q);
        end
    end

    assign stat_mispredicts       = mis_cnt_q;
    assign stat_correct           = cor_cnt_q;
    assign stat_full_stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_free_list_ckpt_ctrl.sv
// Directed self-checking bench for free_list_ckpt_ctrl (default config).
// Inputs change 1ns after posedge; outputs sampled before the next edge.
module tb_free_list_ckpt_ctrl;

    logic        clock;
    logic        reset;
    logic        ckpt_req;
    logic [63:0] ckpt_free_list;
    logic        ckpt_grant;
    logic [1:0]  ckpt_tag;
    logic        ckpt_full;
    logic        resolve_valid;
    logic [1:0]  resolve_tag;
    logic        resolve_mispredict;
    logic        restore_flag;
    logic [63:0] free_list_restore;
    logic [3:0]  live_mask;
`ifdef CKPT_STATS_EN
    logic [31:0] stat_mispredicts;
    logic [31:0] stat_correct;
    logic [31:0] stat_full_stall_cycles;
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] SA = 64'h0000_0000_0000_00AA;
    localparam logic [63:0] SB = 64'h0000_0000_0000_BB00;
    localparam logic [63:0] SC = 64'h0000_0000_00CC_0000;
    localparam logic [63:0] SD = 64'h1111_0000_0000_0000;
    localparam logic [63:0] SE = 64'h2222_0000_0000_0000;
    localparam logic [63:0] SF = 64'h3333_0000_0000_0000;
    localparam logic [63:0] SG = 64'h4444_0000_0000_0000;

    free_list_ckpt_ctrl dut (
        .clock              (clock),
        .reset              (reset),
        .ckpt_req           (ckpt_req),
        .ckpt_free_list     (ckpt_free_list),
        .ckpt_grant         (ckpt_grant),
        .ckpt_tag           (ckpt_tag),
        .ckpt_full          (ckpt_full),
        .resolve_valid      (resolve_valid),
        .resolve_tag        (resolve_tag),
        .resolve_mispredict (resolve_mispredict),
        .restore_flag       (restore_flag),
        .free_list_restore  (free_list_restore),
        .live_mask          (live_mask)
`ifdef CKPT_STATS_EN
        ,
        .stat_mispredicts       (stat_mispredicts),
        .stat_correct           (stat_correct),
        .stat_full_stall_cycles (stat_full_stall_cycles)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        ckpt_req           = 1'b0;
        ckpt_free_list     = '0;
        resolve_valid      = 1'b0;
        resolve_tag        = '0;
        resolve_mispredict = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic alloc(input logic [63:0] snap, input logic [1:0] exp_tag,
                         input string tag);
        ckpt_req       = 1'b1;
        ckpt_free_list = snap;
        #1;
        chk({tag, "_grant"}, ckpt_grant, 1);
        chk({tag, "_tag"}, ckpt_tag, exp_tag);
        tick();
        idle();
    endtask

    task automatic resolve(input logic [1:0] t, input logic m);
        resolve_valid      = 1'b1;
        resolve_tag        = t;
        resolve_mispredict = m;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_live", live_mask, 0);
        chk("rst_rflag", restore_flag, 0);
        chk("rst_rdata", free_list_restore, 0);
        chk("rst_full", ckpt_full, 0);
        chk("rst_grant", ckpt_grant, 0);

        // Test 1: first allocation
        alloc(64'hFFFF_0000_0000_0000, 2'd0, "t1");
        chk("t1_live", live_mask, 4'b0001);

        // Test 2: fill, full, correct resolve while full
        for (int i = 1; i < 4; i++) alloc(64'(i), 2'(i), "t2_fill");
        chk("t2_live_all", live_mask, 4'b1111);
        chk("t2_full", ckpt_full, 1);
        ckpt_req = 1'b1;
        resolve(2'd2, 1'b0);
        #1;
        chk("t2_grant_full", ckpt_grant, 0);
        chk("t2_full_same", ckpt_full, 1);
        tick();
        idle();
        chk("t2_full_drop", ckpt_full, 0);
        chk("t2_live_1011", live_mask, 4'b1011);
        alloc(64'h55, 2'd2, "t2_reuse");
        chk("t2_live_refull", live_mask, 4'b1111);

        // Test 3: mispredict middle tag
        do_reset();
        alloc(SA, 2'd0, "t3_a");
        alloc(SB, 2'd1, "t3_b");
        alloc(SC, 2'd2, "t3_c");
        resolve(2'd1, 1'b1);
        tick();
        idle();
        chk("t3_rflag", restore_flag, 1);
        chk("t3_rdata", free_list_restore, SB);
        chk("t3_live", live_mask, 4'b0001);
        tick();
        chk("t3_rflag_off", restore_flag, 0);
        chk("t3_rdata_hold", free_list_restore, SB);

        // Test 4: mispredict with simultaneous request
        ckpt_req = 1'b1;
        ckpt_free_list = SD;
        resolve(2'd0, 1'b1);
        #1;
        chk("t4_grant_squash", ckpt_grant, 0);
        tick();
        resolve_valid = 1'b0;
        #1;
        chk("t4_rflag", restore_flag, 1);
        chk("t4_rdata", free_list_restore, SA);
        chk("t4_live", live_mask, 0);
        chk("t4_grant_restore", ckpt_grant, 0);
        tick();
        #1;
        chk("t4_grant_run", ckpt_grant, 1);
        chk("t4_tag_run", ckpt_tag, 0);
        tick();
        idle();
        chk("t4_live_after", live_mask, 4'b0001);

        // Test 5: correct resolve with request; age masks
        do_reset();
        alloc(SD, 2'd0, "t5_d");
        alloc(SE, 2'd1, "t5_e");
        resolve(2'd0, 1'b0);
        ckpt_req = 1'b1;
        ckpt_free_list = SF;
        #1;
        chk("t5_grant", ckpt_grant, 1);
        chk("t5_tag", ckpt_tag, 2);
        tick();
        idle();
        chk("t5_live_0110", live_mask, 4'b0110);
        alloc(SG, 2'd0, "t5_g");
        chk("t5_live_0111", live_mask, 4'b0111);
        resolve(2'd0, 1'b1);
        tick();
        idle();
        chk("t5_kill0_live", live_mask, 4'b0110);
        chk("t5_kill0_rdata", free_list_restore, SG);
        tick();
        resolve(2'd1, 1'b1);
        tick();
        idle();
        chk("t5_kill1_live", live_mask, 0);
        chk("t5_kill1_rflag", restore_flag, 1);
        chk("t5_kill1_rdata", free_list_restore, SE);

        // Test 6: reset during RESTORE, invalid-tag resolve
        do_reset();
        alloc(SA, 2'd0, "t6_a");
        alloc(SB, 2'd1, "t6_b");
        resolve(2'd1, 1'b1);
        tick();
        idle();
        chk("t6_in_restore", restore_flag, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_rst_rflag", restore_flag, 0);
        chk("t6_rst_live", live_mask, 0);
        chk("t6_rst_rdata", free_list_restore, 0);
        resolve(2'd3, 1'b1);
        tick();
        idle();
        chk("t6_inv_rflag", restore_flag, 0);
        chk("t6_inv_live", live_mask, 0);
        ckpt_req = 1'b1;
        #1;
        chk("t6_run_grant", ckpt_grant, 1);
        chk("t6_run_tag", ckpt_tag, 0);
        tick();
        idle();
        chk("t6_run_live", live_mask, 4'b0001);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/free_list_ckpt_ctrl.md
Name: free_list_ckpt_ctrl

Overview:
Branch-checkpoint controller for the physical-register free list. It allocates a checkpoint tag to each dispatching branch and captures the free-list snapshot for that branch. It tracks the age relationship between checkpoints and, on resolve, either releases the checkpoint or drives the registered restore_flag / free_list_restore pair into the free list. It sits between dispatch, the branch unit and the free list.

Parameters:
NUM_CKPT, 4, number of checkpoint entries (max in-flight unresolved branches); power of two, 2..16
PHYS_REG_SZ, 64, width of free-list bit-vector
CKPT_ID_BITS, $clog2(NUM_CKPT), tag width

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
ckpt_req  in  1  dispatch has a branch this cycle needing a checkpoint
ckpt_free_list  in  PHYS_REG_SZ  free list as seen after this cycle's dispatch allocation (snapshot to store)
ckpt_grant  out  1  checkpoint allocated this cycle (combinational)
ckpt_tag  out  CKPT_ID_BITS  tag allocated; valid when ckpt_grant
ckpt_full  out  1  no free entry (registered state, combinational decode); dispatch must stall branches
resolve_valid  in  1  branch unit resolving a branch
resolve_tag  in  CKPT_ID_BITS  tag being resolved
resolve_mispredict  in  1  1 = mispredict, 0 = correct
restore_flag  out  1  registered; pulses one cycle after a mispredict
free_list_restore  out  PHYS_REG_SZ  registered snapshot for the mispredicted tag; valid with restore_flag
live_mask  out  NUM_CKPT  registered valid bits of the entries (branch mask for younger instructions)

Behaviour:
- Storage: per entry valid bit, PHYS_REG_SZ snapshot, NUM_CKPT-bit older_mask (the live entries at the time of allocation).
- Allocation: lowest-index invalid entry, based on current-cycle valid bits only. An entry freed in the same cycle cannot be reused until the next cycle.
- ckpt_grant = ckpt_req & ~ckpt_full & ~squash_now & (state==RUN). squash_now = resolve_valid & resolve_mispredict.
- On grant, next cycle: the entry becomes valid, snapshot = ckpt_free_list, and older_mask = live_mask with any entry freed this cycle cleared.
- Correct resolve of tag t: clear valid[t] and clear bit t in every older_mask, next cycle.
- Mispredict of tag t:
  - Next cycle, clear valid[t] and valid[j] for every j whose older_mask[j] is set (all younger entries).
  - Next cycle, restore_flag=1 and free_list_restore=snapshot[t].
- Resolve of an invalid tag: ignored. No state change and no restore.
- FSM has two states:
  - RUN: normal operation. A mispredict moves the FSM to RESTORE.
  - RESTORE: lasts exactly one cycle, with restore_flag=1. ckpt_grant is forced 0 and resolves are ignored, because the branch unit flushes younger resolves. The FSM then returns to RUN.
- Simultaneous events:
  - Mispredict plus ckpt_req: no grant, because the new branch is younger and squashed.
  - Correct resolve plus ckpt_req: both take effect, and the new entry's older_mask excludes t.
  - Full plus correct resolve: ckpt_full stays 1 this cycle and drops the next cycle.
- Reset: all valid=0, state=RUN, restore_flag=0, free_list_restore=0, live_mask=0. Reset dominates all inputs, including mid-RESTORE.
- ckpt_full = &valid. free_list_restore holds its last value when restore_flag=0.

Optional Feature:
CKPT_STATS_EN:
- When defined, adds three outputs: stat_mispredicts (32b), stat_correct (32b) and stat_full_stall_cycles (32b, counts ckpt_req & ckpt_full).
- All three counters are cleared on reset and saturate at all-ones.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package holds the CKPT_TAG typedef (logic [CKPT_ID_BITS-1:0]), the CKPT_ENTRY struct {valid, snapshot, older_mask}, and the NUM_CKPT / CKPT_ID_BITS constants alongside PHYS_REG_SZ_R10K.
- The lowest-free-entry picker is one sub-module, ckpt_alloc_picker: a priority encoder that outputs idx and found.

Test Plan:
1. Reset, then ckpt_req with ckpt_free_list=64'hFFFF_0000_0000_0000 -> ckpt_grant=1, ckpt_tag=0; next cycle live_mask=4'b0001.
2. Four consecutive grants (tags 0..3), then ckpt_req -> ckpt_full=1 and ckpt_grant=0. Correct resolve of tag 2 -> next cycle ckpt_full=0 and live_mask=4'b1011; the next request gets tag 2.
3. Tags 0,1,2 allocated with snapshots A,B,C, then mispredict tag 1 -> next cycle restore_flag=1, free_list_restore=B, live_mask=4'b0001; the cycle after, restore_flag=0.
4. Mispredict tag 0 and ckpt_req in the same cycle -> ckpt_grant=0. The next cycle is RESTORE with ckpt_grant=0 despite ckpt_req. The cycle after that, a grant with tag 0.
5. Tags 0,1 live, correct resolve 0 and new req in the same cycle -> new entry tag 2 with older_mask=4'b0010. Then mispredict 1 -> live_mask=0.
6. Reset asserted during RESTORE -> next cycle restore_flag=0 and live_mask=0. Resolve of an invalid tag 3 -> no restore_flag.
